// File: rtl/bbox_sample_iter.sv
// bbox_sample_iter: walks every subsample position inside a triangle's
// clipped bounding box in raster order, one sample per cycle. The triangle
// and its color are latched at accept and forwarded with each sample.
// Upstream is held off with an active-low halt while a box is being walked.
// Optional build macro: ITER_PERF_COUNT_EN adds sample/triangle counters.
// Coordinates are two's-complement fixed point; SIGFIG bits, RADIX fraction bits.
module bbox_sample_iter #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S,
    input  logic [COLORS-1:0][SIGFIG-1:0]          color_R13U,
    input  logic [1:0][1:0][SIGFIG-1:0]            box_R13S,
    input  logic                                  validTri_R13H,
    input  logic [3:0]                            subSample_RnnnnU,
    output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
    output logic [COLORS-1:0][SIGFIG-1:0]          color_R14U,
    output logic [1:0][SIGFIG-1:0]                 sample_R14S,
    output logic                                  validSamp_R14H,
    output logic                                  halt_RnnnnL
`ifdef ITER_PERF_COUNT_EN
    ,
    output logic [31:0]                           sampCount_RnnnnU,
    output logic [31:0]                           triCount_RnnnnU
`endif
);

    typedef enum logic {WAIT, TEST} state_t;

    state_t                      state_reg, state_next;
    logic [SIGFIG-1:0]           step_sel;
    logic [SIGFIG-1:0]           mask_sel;
    logic [1:0][1:0][SIGFIG-1:0] snap_box;
    logic [1:0][SIGFIG-1:0]      ll_reg;
    logic [1:0][SIGFIG-1:0]      ur_reg;
    logic [1:0][SIGFIG-1:0]      sample_reg;
    logic [SIGFIG-1:0]           step_reg;
    logic                        accept;
    logic                        box_ok;
    logic                        last_x;
    logic                        last_y;

    // Step size from the one-hot rate; anything not one-hot falls back to 1x
    always_comb begin
        step_sel = SIGFIG'(1) << RADIX;
        case (subSample_RnnnnU)
            4'b1000: step_sel = SIGFIG'(1) << RADIX;
            4'b0100: step_sel = SIGFIG'(1) << (RADIX - 1);
            4'b0010: step_sel = SIGFIG'(1) << (RADIX - 2);
            4'b0001: step_sel = SIGFIG'(1) << (RADIX - 3);
            default: step_sel = SIGFIG'(1) << RADIX;
        endcase
    end

    assign mask_sel = ~(step_sel - SIGFIG'(1));

    // Snap both corners down onto the sample grid (clearing low bits floors
    // toward minus infinity, so negative coordinates land correctly too)
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_corner
            for (genvar gj = 0; gj < 2; gj++) begin : g_axis
                assign snap_box[gi][gj] = box_R13S[gi][gj] & mask_sel;
            end
        end
    endgenerate

    assign box_ok = ($signed(snap_box[1][0]) >= $signed(snap_box[0][0])) &&
                    ($signed(snap_box[1][1]) >= $signed(snap_box[0][1]));
    assign accept = (state_reg == WAIT) && validTri_R13H;
    assign last_x = (sample_reg[0] == ur_reg[0]);
    assign last_y = (sample_reg[1] == ur_reg[1]);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= WAIT;
        else      state_reg <= state_next;
    end

    // Next state: enter TEST only for non-empty boxes, leave after the last sample
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            WAIT: if (accept && box_ok) state_next = TEST;
            TEST: if (last_x && last_y) state_next = WAIT;
            default: state_next = WAIT;
        endcase
    end

    // Latch the triangle at accept, then advance the sample position in raster order
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tri_R14S   <= '0;
            color_R14U <= '0;
            sample_reg <= '0;
            ll_reg     <= '0;
            ur_reg     <= '0;
            step_reg   <= '0;
        end else if (accept) begin
            tri_R14S   <= tri_R13S;
            color_R14U <= color_R13U;
            ll_reg     <= snap_box[0];
            ur_reg     <= snap_box[1];
            sample_reg <= snap_box[0];
            step_reg   <= step_sel;
        end else if (state_reg == TEST) begin
            if (!last_x) begin
                sample_reg[0] <= sample_reg[0] + step_reg;
            end else if (!last_y) begin
                sample_reg[0] <= ll_reg[0];
                sample_reg[1] <= sample_reg[1] + step_reg;
            end
        end
    end

    assign sample_R14S    = sample_reg;
    assign validSamp_R14H = (state_reg == TEST);
    assign halt_RnnnnL    = (state_reg == WAIT);

`ifdef ITER_PERF_COUNT_EN
    // Free-running wrap-around counters of emitted samples and accepted triangles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sampCount_RnnnnU <= '0;
            triCount_RnnnnU  <= '0;
        end else begin
            if (state_reg == TEST) sampCount_RnnnnU <= sampCount_RnnnnU + 32'd1;
            if (accept)            triCount_RnnnnU  <= triCount_RnnnnU + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bbox_sample_iter.sv
// Testbench for bbox_sample_iter: scoreboard of expected samples built from
// a raster-walk model, compared whenever the DUT presents a valid sample.
module tb_bbox_sample_iter;

    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S = '0;
    logic [COLORS-1:0][SIGFIG-1:0]          color_R13U = '0;
    logic [1:0][1:0][SIGFIG-1:0]            box_R13S = '0;
    logic                                   validTri_R13H = 1'b0;
    logic [3:0]                             subSample_RnnnnU = 4'b1000;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S;
    logic [COLORS-1:0][SIGFIG-1:0]          color_R14U;
    logic [1:0][SIGFIG-1:0]                 sample_R14S;
    logic                                   validSamp_R14H;
    logic                                   halt_RnnnnL;
`ifdef ITER_PERF_COUNT_EN
    logic [31:0] sampCount_RnnnnU;
    logic [31:0] triCount_RnnnnU;
`endif

    typedef struct {
        logic [23:0] x;
        logic [23:0] y;
        logic [23:0] t;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    bbox_sample_iter #(
        .SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .tri_R13S         (tri_R13S),
        .color_R13U       (color_R13U),
        .box_R13S         (box_R13S),
        .validTri_R13H    (validTri_R13H),
        .subSample_RnnnnU (subSample_RnnnnU),
        .tri_R14S         (tri_R14S),
        .color_R14U       (color_R14U),
        .sample_R14S      (sample_R14S),
        .validSamp_R14H   (validSamp_R14H),
        .halt_RnnnnL      (halt_RnnnnL)
`ifdef ITER_PERF_COUNT_EN
        ,
        .sampCount_RnnnnU (sampCount_RnnnnU),
        .triCount_RnnnnU  (triCount_RnnnnU)
`endif
    );

    always #5 clk = ~clk;

    // Scoreboard: every valid sample must match the head of the expected queue
    always @(negedge clk) begin
        exp_t e;
        if (rst && validSamp_R14H) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_sample got (%h,%h) want no sample", sample_R14S[0], sample_R14S[1]);
            end else begin
                e = exp_q.pop_front();
                if (sample_R14S[0] !== e.x || sample_R14S[1] !== e.y ||
                    tri_R14S[0][0] !== e.t || color_R14U[0] !== e.t + 24'd16 || halt_RnnnnL !== 1'b0) begin
                    errors++;
                    $display("FAIL sample got (%h,%h) tri=%h col=%h halt=%b want (%h,%h) tri=%h col=%h halt=0",
                             sample_R14S[0], sample_R14S[1], tri_R14S[0][0], color_R14U[0], halt_RnnnnL,
                             e.x, e.y, e.t, e.t + 24'd16);
                end else begin
                    $display("sample (%h,%h) tri=%h ok", e.x, e.y, e.t);
                end
            end
        end
    end

    // Reference raster walk: snap corners, then emit every grid point row by row
    task automatic push_expected(input logic [23:0] llx, input logic [23:0] lly,
                                 input logic [23:0] urx, input logic [23:0] ury,
                                 input logic [3:0] sub, input logic [23:0] tag);
        int   step, sx, sy, ex, ey;
        exp_t e;
        case (sub)
            4'b1000: step = 1024;
            4'b0100: step = 512;
            4'b0010: step = 256;
            4'b0001: step = 128;
            default: step = 1024;
        endcase
        sx = int'($signed(llx)) & ~(step - 1);
        sy = int'($signed(lly)) & ~(step - 1);
        ex = int'($signed(urx)) & ~(step - 1);
        ey = int'($signed(ury)) & ~(step - 1);
        if (ex < sx || ey < sy) return;
        for (int y = sy; y <= ey; y += step) begin
            for (int x = sx; x <= ex; x += step) begin
                e.x = 24'(x);
                e.y = 24'(y);
                e.t = tag;
                exp_q.push_back(e);
            end
        end
    endtask

    // Present a triangle at a negedge (validTri stays high until the caller drops it)
    task automatic present_tri(input logic [23:0] llx, input logic [23:0] lly,
                               input logic [23:0] urx, input logic [23:0] ury,
                               input logic [3:0] sub, input logic [23:0] tag);
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
                tri_R13S[v][a] = tag + 24'(v * AXIS + a);
        for (int c = 0; c < COLORS; c++)
            color_R13U[c] = tag + 24'(16 + c);
        box_R13S[0][0]   = llx;
        box_R13S[0][1]   = lly;
        box_R13S[1][0]   = urx;
        box_R13S[1][1]   = ury;
        subSample_RnnnnU = sub;
        validTri_R13H    = 1'b1;
        push_expected(llx, lly, urx, ury, sub, tag);
    endtask

    // One-cycle validTri pulse
    task automatic drive_tri(input logic [23:0] llx, input logic [23:0] lly,
                             input logic [23:0] urx, input logic [23:0] ury,
                             input logic [3:0] sub, input logic [23:0] tag);
        @(negedge clk);
        present_tri(llx, lly, urx, ury, sub, tag);
        @(negedge clk);
        validTri_R13H = 1'b0;
    endtask

    // Wait (bounded) for the scoreboard to empty, then expect the idle state
    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout got %0d samples pending want 0", name, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        checks++;
        if (validSamp_R14H !== 1'b0 || halt_RnnnnL !== 1'b1) begin
            errors++;
            $display("FAIL %s_idle got valid=%b halt=%b want valid=0 halt=1", name, validSamp_R14H, halt_RnnnnL);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (validSamp_R14H !== 1'b0 || halt_RnnnnL !== 1'b1 || sample_R14S !== '0 ||
            tri_R14S !== '0 || color_R14U !== '0) begin
            errors++;
            $display("FAIL reset_state got valid=%b halt=%b samp=%h want valid=0 halt=1 samp=0",
                     validSamp_R14H, halt_RnnnnL, sample_R14S);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        $display("reset released");
    endtask

    task automatic test_1x();
        @(negedge clk);
        present_tri(24'h0, 24'h0, 24'h400, 24'h400, 4'b1000, 24'h000100);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) validTri_R13H = 1'b0;
            checks++;
            if (validSamp_R14H !== 1'b1 || halt_RnnnnL !== 1'b0) begin
                errors++;
                $display("FAIL 1x_run cycle %0d got valid=%b halt=%b want valid=1 halt=0",
                         i, validSamp_R14H, halt_RnnnnL);
            end
        end
        wait_drain("1x");
    endtask

    task automatic test_4x();
        drive_tri(24'h300, 24'h0, 24'h400, 24'h0, 4'b0100, 24'h000200);
        wait_drain("4x");
    endtask

    task automatic test_rates();
        drive_tri(24'h0, 24'h0, 24'h100, 24'h100, 4'b0010, 24'h000300);
        wait_drain("16x");
        drive_tri(24'h40, 24'h0, 24'hC0, 24'h0, 4'b0001, 24'h000400);
        wait_drain("64x");
        drive_tri(24'h0, 24'h0, 24'h400, 24'h0, 4'b1100, 24'h000500);
        wait_drain("non_onehot");
    endtask

    task automatic test_degenerate();
        drive_tri(24'h800, 24'h0, 24'h400, 24'h0, 4'b1000, 24'h000600);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (validSamp_R14H !== 1'b0 || halt_RnnnnL !== 1'b1) begin
                errors++;
                $display("FAIL degenerate cycle %0d got valid=%b halt=%b want valid=0 halt=1",
                         i, validSamp_R14H, halt_RnnnnL);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_negative();
        drive_tri(24'hFFFC00, 24'hFFFC00, 24'h0, 24'hFFFC00, 4'b1000, 24'h000700);
        wait_drain("negative");
    endtask

    task automatic test_reset_mid_run();
        drive_tri(24'h0, 24'h0, 24'h400, 24'h400, 4'b1000, 24'h000800);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (validSamp_R14H !== 1'b0 || halt_RnnnnL !== 1'b1 || sample_R14S !== '0 || tri_R14S !== '0) begin
            errors++;
            $display("FAIL mid_reset got valid=%b halt=%b samp=%h want valid=0 halt=1 samp=0",
                     validSamp_R14H, halt_RnnnnL, sample_R14S);
        end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (validSamp_R14H !== 1'b0) begin
                errors++;
                $display("FAIL after_reset cycle %0d got valid=%b want valid=0", i, validSamp_R14H);
            end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        present_tri(24'h0, 24'h0, 24'h400, 24'h0, 4'b1000, 24'h000900);
        @(negedge clk);
        present_tri(24'h0, 24'h400, 24'h400, 24'h400, 4'b1000, 24'h000A00);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (validSamp_R14H !== 1'b0 || halt_RnnnnL !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap got valid=%b halt=%b want valid=0 halt=1", validSamp_R14H, halt_RnnnnL);
        end
        @(negedge clk);
        validTri_R13H = 1'b0;
        checks++;
        if (validSamp_R14H !== 1'b1 || tri_R14S[0][0] !== 24'h000A00) begin
            errors++;
            $display("FAIL b2b_second got valid=%b tri=%h want valid=1 tri=000a00", validSamp_R14H, tri_R14S[0][0]);
        end
        wait_drain("b2b");
    endtask

    initial begin
        test_reset();
        test_1x();
        test_4x();
        test_rates();
        test_degenerate();
        test_negative();
        test_reset_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
